// File: rtl/chain_pkg.sv
// Shared types and defaults for the chamber-chain inlet sequencer.
// Included first so the state enum is visible to every unit.
package chain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DOSE,
    STEP,
    SETTLE
  } state_e;

  localparam int N_CHAMBERS  = 96;
  localparam int STEP_CYCLES = 16;
  localparam int DOSE_W      = 8;

endpackage

// File: rtl/chain_occ_tracker.sv
// Occupancy shift register for the chamber chain and the single
// exit slot that holds the sample leaving the last chamber.
module chain_occ_tracker
  import chain_pkg::*;
#(
  parameter int N = N_CHAMBERS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_i,
  input  logic         ins_i,
  input  logic         out_ready_i,
  output logic [N-1:0] occ_o,
  output logic         out_valid_o,
  output logic         stall_o
);

  logic [N-1:0] occ_q, occ_d;
  logic         vld_q, vld_d;
  logic         set, clr;

  // A full slot only blocks the step when it is not draining now.
  assign stall_o = occ_q[N-1] & vld_q & ~out_ready_i;

  assign set = shift_i & occ_q[N-1];
  assign clr = vld_q & out_ready_i;

  always_comb begin
    occ_d = occ_q;
    if (shift_i) begin
      occ_d = {occ_q[N-2:0], ins_i};
    end
    vld_d = set | (vld_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      vld_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      vld_q <= vld_d;
    end
  end

  assign occ_o       = occ_q;
  assign out_valid_o = vld_q;

endmodule

// File: rtl/chain_inlet_sequencer.sv
// Inlet controller for the chamber chain: meters doses through the
// valve, issues pump steps and exposes exiting samples downstream.
module chain_inlet_sequencer #(
  parameter int N_CHAMBERS  = chain_pkg::N_CHAMBERS,
  parameter int DOSE_W      = chain_pkg::DOSE_W,
  parameter int STEP_CYCLES = chain_pkg::STEP_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DOSE_W-1:0]     req_dose,
  output logic                  valve_in,
  output logic                  pump_step,
  output logic [N_CHAMBERS-1:0] occ,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);
  import chain_pkg::*;

  localparam int SW = $clog2(STEP_CYCLES);
  localparam logic [SW-1:0] SET_LD = SW'(STEP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [DOSE_W-1:0] dose_q, dose_d;
  logic [SW-1:0]     set_q, set_d;
  logic              ins_q, ins_d;
  logic              stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dose_q  <= '0;
      set_q   <= '0;
      ins_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dose_q  <= dose_d;
      set_q   <= set_d;
      ins_q   <= ins_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dose_d    = dose_q;
    set_d     = set_q;
    ins_d     = ins_q;
    req_ready = 1'b0;
    valve_in  = 1'b0;
    pump_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = ~rst;
        if (req_valid) begin
          dose_d  = req_dose;
          ins_d   = |req_dose;
          state_d = (|req_dose) ? DOSE : STEP;
        end else if (|occ) begin
          ins_d   = 1'b0;
          state_d = STEP;
        end
      end
      DOSE: begin
        valve_in = 1'b1;
        dose_d   = dose_q - DOSE_W'(1);
        if (dose_q == DOSE_W'(1)) begin
          state_d = STEP;
        end
      end
      STEP: begin
        if (!stall) begin
          pump_step = 1'b1;
          set_d     = SET_LD;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        set_d = set_q - SW'(1);
        if (set_q == SW'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  chain_occ_tracker #(
    .N(N_CHAMBERS)
  ) u_occ (
    .clk         (clk),
    .rst         (rst),
    .shift_i     (pump_step),
    .ins_i       (ins_q),
    .out_ready_i (out_ready),
    .occ_o       (occ),
    .out_valid_o (out_valid),
    .stall_o     (stall)
  );

endmodule
